// File: rtl/ps2_host_tx_if.sv
// Host-side command handshake for the PS/2 host transmitter.
// The master offers bytes; the slave (transmitter) reports status and completion pulses.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  busy,
    input  tx_done,
    input  tx_error
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output busy,
    output tx_done,
    output tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 11-bit frame and device ACK.
// Pin outputs are open-drain controls: 0 pulls the line low, 1 releases it.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic          clk,
  input  logic          n_reset,
  ps2_host_tx_if.slave  host,
  input  logic          ps2_clk_in,
  input  logic          ps2_dat_in,
  output logic          ps2_clk_out,
  output logic          ps2_dat_out
);

  localparam int MAX_CNT = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_START = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic logic frame_bit(input logic [7:0] d, input logic p, input logic [3:0] idx);
    logic b;
    case (idx)
      4'd0, 4'd1, 4'd2, 4'd3,
      4'd4, 4'd5, 4'd6, 4'd7: b = d[idx[2:0]];
      4'd8:                   b = p;
      default:                b = 1'b1;
    endcase
    return b;
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       idx_r, idx_s;
  logic [7:0]       data_r, data_s;
  logic             parity_r, parity_s;
  logic             clk_out_r, clk_out_s;
  logic             dat_out_r, dat_out_s;
  logic             done_r, done_s;
  logic             error_r, error_s;
  logic             busy_r, ready_r;
  logic [1:0]       clk_sync_r, dat_sync_r;
  logic             clk_prev_r;
  logic             fall_s;
  logic             timeout_s;

  // Two-stage synchronisers on the raw pins plus the previous clock level for edge detection.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      clk_sync_r <= 2'b11;
      dat_sync_r <= 2'b11;
      clk_prev_r <= 1'b1;
    end else begin
      clk_sync_r <= {clk_sync_r[0], ps2_clk_in};
      dat_sync_r <= {dat_sync_r[0], ps2_dat_in};
      clk_prev_r <= clk_sync_r[1];
    end
  end

  assign fall_s = clk_prev_r & ~clk_sync_r[1];

  // State, counters and all outputs are registered from the next-state decode.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      idx_r     <= 4'd0;
      data_r    <= 8'h00;
      parity_r  <= 1'b0;
      clk_out_r <= 1'b1;
      dat_out_r <= 1'b1;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      busy_r    <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      data_r    <= data_s;
      parity_r  <= parity_s;
      clk_out_r <= clk_out_s;
      dat_out_r <= dat_out_s;
      done_r    <= done_s;
      error_r   <= error_s;
      busy_r    <= (state_s != ST_IDLE);
      ready_r   <= (state_s == ST_IDLE);
    end
  end

  // Next-state and next-output decode; the shared counter times both inhibit and timeout.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    data_s    = data_r;
    parity_s  = parity_r;
    clk_out_s = clk_out_r;
    dat_out_s = dat_out_r;
    done_s    = 1'b0;
    error_s   = 1'b0;
    timeout_s = (cnt_r == TO_LAST);

    case (state_r)
      ST_IDLE: begin
        clk_out_s = 1'b1;
        dat_out_s = 1'b1;
        cnt_s     = CNT_ZERO;
        if (host.tx_valid) begin
          data_s    = host.tx_data;
          parity_s  = odd_parity(host.tx_data);
          clk_out_s = 1'b0;
          state_s   = ST_INHIBIT;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_INHIBIT: begin
        clk_out_s = 1'b0;
        if (cnt_r == INH_LAST) begin
          clk_out_s = 1'b1;
          dat_out_s = 1'b0;
          cnt_s     = CNT_ZERO;
          state_s   = ST_RTS;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
          // Start bit goes out on the last inhibit cycle, ahead of the clock release.
          if (cnt_r == INH_START) begin
            dat_out_s = 1'b0;
          end else begin
            dat_out_s = dat_out_r;
          end
        end
      end

      ST_RTS, ST_SHIFT, ST_ACK, ST_WAIT_IDLE: begin
        if (timeout_s) begin
          error_s   = 1'b1;
          clk_out_s = 1'b1;
          dat_out_s = 1'b1;
          cnt_s     = CNT_ZERO;
          state_s   = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
          case (state_r)
            ST_RTS: begin
              clk_out_s = 1'b1;
              dat_out_s = 1'b0;
              idx_s     = 4'd0;
              state_s   = ST_SHIFT;
            end
            ST_SHIFT: begin
              if (fall_s) begin
                dat_out_s = frame_bit(data_r, parity_r, idx_r);
                idx_s     = idx_r + 4'd1;
                if (idx_r == 4'd9) begin
                  state_s = ST_ACK;
                end else begin
                  state_s = ST_SHIFT;
                end
              end else begin
                state_s = ST_SHIFT;
              end
            end
            ST_ACK: begin
              if (fall_s) begin
                if (!dat_sync_r[1]) begin
                  state_s = ST_WAIT_IDLE;
                end else begin
                  error_s   = 1'b1;
                  clk_out_s = 1'b1;
                  dat_out_s = 1'b1;
                  cnt_s     = CNT_ZERO;
                  state_s   = ST_IDLE;
                end
              end else begin
                state_s = ST_ACK;
              end
            end
            ST_WAIT_IDLE: begin
              if (clk_sync_r[1] && dat_sync_r[1]) begin
                done_s  = 1'b1;
                cnt_s   = CNT_ZERO;
                state_s = ST_IDLE;
              end else begin
                state_s = ST_WAIT_IDLE;
              end
            end
            default: begin
              state_s = ST_IDLE;
            end
          endcase
        end
      end

      default: begin
        clk_out_s = 1'b1;
        dat_out_s = 1'b1;
        cnt_s     = CNT_ZERO;
        state_s   = ST_IDLE;
      end
    endcase
  end

  assign ps2_clk_out   = clk_out_r;
  assign ps2_dat_out   = dat_out_r;
  assign host.tx_ready = ready_r;
  assign host.busy     = busy_r;
  assign host.tx_done  = done_r;
  assign host.tx_error = error_r;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends command bytes (LED set, typematic rate, reset, mouse enable) to the keyboard or mouse port. It drives the open-drain pins through the active-low *_out convention used at the board toplevel, where 0 pulls the line low and 1 releases it. It sits beside the existing PS/2 receiver, shares the same pins, and exposes `busy` so the receiver ignores host-generated clock edges.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles the clock line is held low before the request-to-send (100 us at 50 MHz); minimum 2.
TIMEOUT_CYCLES, 750000, maximum clk cycles from clock release to ACK completion (15 ms at 50 MHz).

Ports:
clk  in  1  system clock; all logic on its rising edge.
n_reset  in  1  asynchronous active-low reset.
tx_data  in  8  byte to transmit, sampled when tx_valid && tx_ready.
tx_valid  in  1  request strobe, level-sensitive.
tx_ready  out  1  high only in IDLE.
busy  out  1  high in every state except IDLE.
tx_done  out  1  one-cycle pulse: device ACK received and bus idle.
tx_error  out  1  one-cycle pulse: missing ACK or timeout.
ps2_clk_in  in  1  raw PS/2 clock pin level.
ps2_dat_in  in  1  raw PS/2 data pin level.
ps2_clk_out  out  1  0 = drive clock low, 1 = release.
ps2_dat_out  out  1  0 = drive data low, 1 = release.

Behaviour:
- Reset is asynchronous. Every state is abandoned at once.
  - Reset values: ps2_clk_out=1, ps2_dat_out=1, tx_ready=1, busy=0, tx_done=0, tx_error=0, state=IDLE, counters=0.
- Pin inputs pass through 2-FF synchronisers.
  - fall = previous synced clk 1 AND current synced clk 0.
  - A pin falling edge is seen as `fall` 3 clk cycles later.
- Frame is 11 bits: start 0, data bits 0-7 LSB first, odd parity (~^tx_data), stop 1, then device ACK.
- States:
  - IDLE: outputs released. On tx_valid: latch tx_data, compute parity, go to INHIBIT next cycle.
  - INHIBIT: ps2_clk_out=0 for INHIBIT_CYCLES cycles. ps2_dat_out=0 on the final cycle (start bit). Then go to RTS.
  - RTS: ps2_clk_out=1, ps2_dat_out=0. Timeout counter cleared and starts counting. Bit index=0. Go to SHIFT.
  - SHIFT: on each `fall`, set ps2_dat_out to the bit at the index, then increment the index.
    - Index 0-7 = data, 8 = parity, 9 = stop (ps2_dat_out=1).
    - The `fall` that completes index 9 moves to ACK.
  - ACK: on the next `fall`, sample synced data.
    - Data 0: go to WAIT_IDLE.
    - Data 1: pulse tx_error, go to IDLE.
  - WAIT_IDLE: when synced clk=1 AND synced data=1, pulse tx_done and go to IDLE.
- Timeout: counter runs in RTS, SHIFT, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES:
  - pulse tx_error;
  - release both lines in the same cycle as the pulse;
  - go to IDLE.
  - Timeout takes priority over a simultaneous `fall`.
- tx_valid outside IDLE is ignored and not queued. tx_valid held high after completion starts a new frame one cycle after returning to IDLE.
- tx_done and tx_error are never high together, and each pulses exactly once per accepted byte.
- The ps2_dat_out change lands within 4 clk cycles of the pin falling edge. The device samples on the rising edge ≥5 us later, so this latency is acceptable.
- Edges on ps2_clk_in during INHIBIT are ignored because the block is driving the clock itself.

Test Plan:
All scenarios run with INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, and a device model that clocks at 400 clk cycles per period.

1. Send 0xED, model ACKs.
   - ps2_clk_out low exactly 20 cycles; ps2_dat_out=0 before clock release.
   - Bits sampled on rising edges: 1,0,1,1,0,1,1,1, parity 1, stop 1.
   - One tx_done pulse, then tx_ready=1.
2. Send 0xF4 → data bits 0,0,1,0,1,1,1,1, parity 0. Send 0x00 → parity 1.
3. Model leaves data high at the ACK edge → exactly one tx_error pulse, no tx_done, both outputs 1, tx_ready=1.
4. Model never clocks after RTS → tx_error 2000 cycles after clock release, lines released.
5. Pulse tx_valid with 0x55 during SHIFT of 0xFF → 0xFF completes unaltered; 0x55 is never sent.
6. Assert n_reset low mid-SHIFT (bit 4) → ps2_clk_out=1 and ps2_dat_out=1 with no clk edge. After release, a new send of 0xED completes normally.
